// File: rtl/axi_slave_resp_push_fsm.sv
// axi_slave_resp_push_fsm
// Upstream push stage of the AXI slave read-response path. Takes one
// completion descriptor (id, beat count, status) and streams its beats into
// the read-response FIFO as {id, data, resp[1:0], last} entries.
// Error completions generate SLVERR beats with zero data and consume no
// input data. A load-able down-counter tracks the remaining beats and
// produces RLAST.
//
// Optional build macro: AXI_RESP_PUSH_STATS_EN adds saturating 16-bit
// completion and error-completion counters as outputs.

module axi_slave_resp_push_fsm #(
    parameter  int ID_W      = 4,
    parameter  int DATA_W    = 64,
    parameter  int MAX_BEATS = 16,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      cpl_valid,
    output logic                      cpl_ready,
    input  logic [ID_W-1:0]           cpl_id,
    input  logic [CNT_W-1:0]          cpl_beats,
    input  logic                      cpl_err,
    input  logic                      dat_valid,
    output logic                      dat_ready,
    input  logic [DATA_W-1:0]         dat_in,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [ID_W+DATA_W+2:0]    fifo_wdata,
`ifdef AXI_RESP_PUSH_STATS_EN
    output logic [15:0]               cpl_done_cnt,
    output logic [15:0]               err_cnt,
`endif
    output logic                      busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [ID_W-1:0]    id_q,    id_d;
    logic               err_q,   err_d;

    logic [CNT_W-1:0]   beats_eff;
    logic               beat_last;

    // Clamp the requested beat count into 1..MAX_BEATS before loading.
    always_comb begin
        beats_eff = cpl_beats;
        if (cpl_beats == '0) begin
            beats_eff = CNT_W'(1);
        end else if (cpl_beats > CNT_W'(MAX_BEATS)) begin
            beats_eff = CNT_W'(MAX_BEATS);
        end
    end

    assign beat_last = (cnt_q == '0);
    assign busy      = (state_q != ST_IDLE);

    // Next-state, handshake and push formatting; outputs are zero-latency.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        err_d      = err_q;
        cpl_ready  = 1'b0;
        dat_ready  = 1'b0;
        fifo_push  = 1'b0;
        fifo_wdata = '0;

        unique case (state_q)
            ST_IDLE: begin
                // Gated by arst so the port reads 0 while reset is held.
                cpl_ready = arst;
                if (cpl_valid && arst) begin
                    id_d    = cpl_id;
                    err_d   = cpl_err;
                    cnt_d   = beats_eff - CNT_W'(1);
                    state_d = cpl_err ? ST_ERR : ST_PUSH;
                end
            end
            ST_PUSH: begin
                dat_ready = !fifo_full;
                fifo_push = dat_valid && !fifo_full;
            end
            ST_ERR: begin
                // Error beats are self-timed; input data is never consumed.
                fifo_push = !fifo_full;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (fifo_push) begin
            fifo_wdata = {id_q,
                          err_q ? {DATA_W{1'b0}} : dat_in,
                          err_q ? RESP_SLVERR : RESP_OKAY,
                          beat_last};
            // Counter holds at zero rather than wrapping.
            cnt_d = beat_last ? cnt_q : cnt_q - CNT_W'(1);
            if (beat_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State, beat counter and latched descriptor fields.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

`ifdef AXI_RESP_PUSH_STATS_EN
    logic [15:0] cpl_done_cnt_q, cpl_done_cnt_d;
    logic [15:0] err_cnt_q,      err_cnt_d;

    // Saturating counts of finished completions and finished error completions.
    always_comb begin
        cpl_done_cnt_d = cpl_done_cnt_q;
        err_cnt_d      = err_cnt_q;
        if (fifo_push && beat_last) begin
            if (cpl_done_cnt_q != 16'hFFFF) begin
                cpl_done_cnt_d = cpl_done_cnt_q + 16'd1;
            end
            if ((state_q == ST_ERR) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cpl_done_cnt_q <= '0;
            err_cnt_q      <= '0;
        end else begin
            cpl_done_cnt_q <= cpl_done_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign cpl_done_cnt = cpl_done_cnt_q;
    assign err_cnt      = err_cnt_q;
`endif

endmodule

// File: tb/tb_axi_slave_resp_push_fsm.sv
// Scoreboard bench for axi_slave_resp_push_fsm: expected FIFO entries are
// queued when a descriptor is issued and popped as pushes appear.
// Build with AXI_RESP_PUSH_STATS_EN defined to also check the statistics.

module tb_axi_slave_resp_push_fsm;

    localparam int ID_W      = 4;
    localparam int DATA_W    = 64;
    localparam int MAX_BEATS = 16;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);
    localparam int WD        = ID_W + DATA_W + 3;

    logic              clk;
    logic              arst;
    logic              cpl_valid;
    logic              cpl_ready;
    logic [ID_W-1:0]   cpl_id;
    logic [CNT_W-1:0]  cpl_beats;
    logic              cpl_err;
    logic              dat_valid;
    logic              dat_ready;
    logic [DATA_W-1:0] dat_in;
    logic              fifo_full;
    logic              fifo_push;
    logic [WD-1:0]     fifo_wdata;
    logic              busy;
`ifdef AXI_RESP_PUSH_STATS_EN
    logic [15:0]       cpl_done_cnt;
    logic [15:0]       err_cnt;
    int                exp_done = 0;
    int                exp_err  = 0;
`endif

    int total = 0;
    int bad   = 0;
    logic [WD-1:0] exp_q[$];
    logic [WD-1:0] mon_exp;

    axi_slave_resp_push_fsm #(
        .ID_W      (ID_W),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .cpl_valid    (cpl_valid),
        .cpl_ready    (cpl_ready),
        .cpl_id       (cpl_id),
        .cpl_beats    (cpl_beats),
        .cpl_err      (cpl_err),
        .dat_valid    (dat_valid),
        .dat_ready    (dat_ready),
        .dat_in       (dat_in),
        .fifo_full    (fifo_full),
        .fifo_push    (fifo_push),
        .fifo_wdata   (fifo_wdata),
`ifdef AXI_RESP_PUSH_STATS_EN
        .cpl_done_cnt (cpl_done_cnt),
        .err_cnt      (err_cnt),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] dval(input logic [ID_W-1:0] id, input int k);
        return {8'hD0, 4'h0, id, 16'hBEEF, 32'(k) * 32'h0101_0101 + 32'h1};
    endfunction

    // Monitor: every push is compared against the head of the scoreboard.
    always @(negedge clk) begin
        if (arst && fifo_push) begin
            $display("push id=%0h data=%0h resp=%0b last=%0b",
                     fifo_wdata[WD-1 -: ID_W], fifo_wdata[DATA_W+2:3],
                     fifo_wdata[2:1], fifo_wdata[0]);
            chk("push_while_full", fifo_full, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_push", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("wdata", fifo_wdata, mon_exp);
`ifdef AXI_RESP_PUSH_STATS_EN
                if (mon_exp[0]) exp_done++;
                if (mon_exp[0] && mon_exp[2:1] == 2'b10) exp_err++;
`endif
            end
        end
    end

    // Issue one completion, stream its beats and check the handshakes.
    // fmask/vmask give fifo_full/dat_valid per burst cycle; stop limits pushes.
    task automatic run_cpl(input logic [ID_W-1:0] id, input logic [CNT_W-1:0] beats,
                           input bit err, input logic [31:0] fmask,
                           input logic [31:0] vmask, input int stop);
        int n, lim, k, cyc;
        bit exp_push, exp_dr;
        n = (beats == 0) ? 1 : ((int'(beats) > MAX_BEATS) ? MAX_BEATS : int'(beats));
        lim = (stop < n) ? stop : n;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({id, err ? {DATA_W{1'b0}} : dval(id, i),
                             err ? 2'b10 : 2'b00, (i == n - 1)});
        end
        @(posedge clk); #1;
        cpl_valid = 1'b1; cpl_id = id; cpl_beats = beats; cpl_err = err;
        dat_valid = 1'b0; fifo_full = 1'b0;
        @(negedge clk);
        chk("cpl_ready_idle", cpl_ready, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        cpl_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < lim && cyc < 300) begin
            fifo_full = fmask[cyc % 32];
            dat_valid = vmask[cyc % 32];
            dat_in    = dval(id, k);
            cpl_valid = vmask[cyc % 32];  // ignored while busy
            @(negedge clk);
            exp_dr   = !err && !fifo_full;
            exp_push = err ? !fifo_full : (dat_valid && !fifo_full);
            chk("busy_burst", busy, 1);
            chk("cpl_ready_burst", cpl_ready, 0);
            chk("dat_ready", dat_ready, exp_dr);
            chk("push_strobe", fifo_push, exp_push);
            if (exp_push) k++;
            cyc++;
            @(posedge clk); #1;
        end
        if (cyc >= 300) chk("burst_timeout", 1, 0);
        cpl_valid = 1'b0; fifo_full = 1'b0; dat_valid = 1'b0;
        if (stop >= n) begin
            @(negedge clk);
            chk("busy_after", busy, 0);
            chk("cpl_ready_after", cpl_ready, 1);
            chk("no_push_after", fifo_push, 0);
            chk("queue_drained", exp_q.size(), 0);
`ifdef AXI_RESP_PUSH_STATS_EN
            chk("cpl_done_cnt", cpl_done_cnt, exp_done);
            chk("err_cnt", err_cnt, exp_err);
`endif
        end
    endtask

    initial begin
        arst = 1'b0; cpl_valid = 1'b0; cpl_id = '0; cpl_beats = '0; cpl_err = 1'b0;
        dat_valid = 1'b0; dat_in = '0; fifo_full = 1'b0;
        @(negedge clk);
        chk("rst_cpl_ready", cpl_ready, 0);
        chk("rst_dat_ready", dat_ready, 0);
        chk("rst_fifo_push", fifo_push, 0);
        chk("rst_fifo_wdata", fifo_wdata, 0);
        chk("rst_busy", busy, 0);
`ifdef AXI_RESP_PUSH_STATS_EN
        chk("rst_cpl_done_cnt", cpl_done_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
`endif
        @(posedge clk); #1;
        arst = 1'b1;

        run_cpl(4'd3,  5'd4,  1'b0, 32'h0,        32'hFFFF_FFFF, 999);
        run_cpl(4'd5,  5'd1,  1'b0, 32'h0,        32'hFFFF_FFFF, 999);
        run_cpl(4'd1,  5'd8,  1'b0, 32'b11100,    32'hFFFF_FFFF, 999);
        run_cpl(4'd7,  5'd2,  1'b1, 32'h0,        32'hFFFF_FFFF, 999);
        run_cpl(4'd4,  5'd0,  1'b0, 32'h0,        32'hFFFF_FFFF, 999);
        run_cpl(4'd6,  5'd19, 1'b0, 32'h0,        32'hFFFF_FFFF, 999);
        run_cpl(4'd10, 5'd5,  1'b0, 32'h0,        32'hFFFF_FF5B, 999);
        run_cpl(4'd11, 5'd3,  1'b1, 32'b0110,     32'hFFFF_FFFF, 999);
        run_cpl(4'd12, 5'd16, 1'b0, 32'h0000_0900, 32'hFFFF_7FEF, 999);

        // Asynchronous reset in the middle of a 6-beat burst.
        run_cpl(4'd2,  5'd6,  1'b0, 32'h0,        32'hFFFF_FFFF, 2);
        dat_valid = 1'b1; fifo_full = 1'b0;
        #2 arst = 1'b0;
        #1;
        chk("midrst_fifo_push", fifo_push, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_dat_ready", dat_ready, 0);
        chk("midrst_cpl_ready", cpl_ready, 0);
        exp_q.delete();
`ifdef AXI_RESP_PUSH_STATS_EN
        exp_done = 0; exp_err = 0;
`endif
        @(posedge clk); #1;
        dat_valid = 1'b0;
        arst = 1'b1;
        run_cpl(4'd9,  5'd2,  1'b0, 32'h0,        32'hFFFF_FFFF, 999);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_slave_resp_push_fsm.md
Name: axi_slave_resp_push_fsm

Overview:
- Upstream push stage of the AXI slave response path.
- Accepts one completion descriptor (ID, beat count, status) plus its data-beat stream from the TL RX completion side.
- Formats each beat as an AXI R-channel entry {id, data, resp, last} and pushes it into the read-response FIFO.
- An embedded load-able down-counter tracks remaining beats and generates RLAST.

Parameters:
- ID_W, 4, AXI ID width
- DATA_W, 64, data beat width
- MAX_BEATS, 16, maximum beats per completion; counter width CNT_W = $clog2(MAX_BEATS+1)

Ports:
- clk  in  1  clock
- arst  in  1  asynchronous reset, active-low
- cpl_valid  in  1  completion descriptor valid
- cpl_ready  out  1  descriptor accepted when cpl_valid && cpl_ready
- cpl_id  in  ID_W  AXI ID of the completion
- cpl_beats  in  CNT_W  number of beats (1..MAX_BEATS)
- cpl_err  in  1  1 = UR/CA completion; respond SLVERR with no data consumed
- dat_valid  in  1  data beat valid
- dat_ready  out  1  data beat consumed when dat_valid && dat_ready
- dat_in  in  DATA_W  data beat
- fifo_full  in  1  response FIFO full
- fifo_push  out  1  write strobe into response FIFO
- fifo_wdata  out  ID_W+DATA_W+3  {id, data, resp[1:0], last}
- busy  out  1  high while not in IDLE

Behaviour:
- Reset (arst low): state=IDLE, counter=0, latched id/err=0, fifo_push=0, fifo_wdata=0, cpl_ready=0, dat_ready=0, busy=0.
- States: IDLE, PUSH, ERR.
- IDLE
  - cpl_ready=1.
  - On handshake: latch cpl_id and cpl_err; load counter with beats-1.
  - Go to ERR if cpl_err=1, else PUSH.
  - Beat-count rules: cpl_beats=0 is treated as 1; cpl_beats>MAX_BEATS saturates to MAX_BEATS.
- PUSH
  - dat_ready = !fifo_full (combinational).
  - On a data handshake, fifo_push=1 in the same cycle; fifo_wdata = {id, dat_in, 2'b00 OKAY, last}.
  - last = (counter==0); counter decrements by 1 and holds at 0 (never wraps).
  - After pushing the last beat: return to IDLE.
- ERR
  - dat_ready=0.
  - Each cycle !fifo_full: push {id, '0, 2'b10 SLVERR, last}, decrement counter.
  - After the last beat: IDLE.
- Timing and throughput
  - fifo_push and fifo_wdata are combinational from state, counter, handshake and fifo_full (zero latency).
  - Registered state/counter updates take effect next cycle.
  - Throughput: 1 beat/cycle. Minimum cost per completion: 1 descriptor cycle + N beat cycles.
- Boundary conditions
  - fifo_full asserted mid-burst: no push, counter holds, dat_ready=0; resume the cycle after it deasserts.
  - dat_valid low mid-burst: no push, counter holds.
  - cpl_valid during PUSH/ERR: ignored (cpl_ready=0); descriptor must stay stable until accepted.
  - Single-beat completion: the first pushed beat carries last=1.
  - arst asserted mid-burst: immediate return to reset values; the partial burst is abandoned, and the FIFO owner must reset too.
- Invariants
  - fifo_push is never asserted while fifo_full=1.
  - Exactly N pushes per accepted completion; last=1 on exactly the Nth.

Optional Feature:
- Macro: AXI_RESP_PUSH_STATS_EN.
- When defined, adds two outputs:
  - cpl_done_cnt [15:0]: increments when a last beat is pushed.
  - err_cnt [15:0]: increments on last beat in ERR.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then cpl_beats=4, id=3, dat_valid held 1, fifo_full=0 -> 4 pushes on consecutive cycles, data D0..D3, resp=00, id=3, last only on 4th; busy high for 4 cycles; IDLE after.
- cpl_beats=1, id=5 -> one push with last=1; cpl_ready high again the next cycle.
- cpl_beats=8, fifo_full high during beats 3-5 -> no push and dat_ready=0 while full; all 8 beats delivered in order, last on 8th.
- cpl_err=1, cpl_beats=2, id=7 -> 2 pushes with resp=10, data=0, last on 2nd; dat_ready stays 0 throughout.
- cpl_beats=0 -> single beat with last=1; cpl_beats=MAX_BEATS+3 -> exactly MAX_BEATS beats pushed.
- arst low after 2 of 6 beats -> fifo_push=0 and busy=0 immediately; new cpl_beats=2 after release completes normally. With AXI_RESP_PUSH_STATS_EN: cpl_done_cnt and err_cnt match the completions finished.
